// File: rtl/switch_link_rx.sv
// ---------------------------------------------------------------------------
// switch_link_rx
//
// Receive-side endpoint for one switch output port. Flits arriving from the
// upstream switch are sorted into one FIFO per virtual channel; a small FSM
// per VC tracks packet boundaries so that every stored flit carries a "last"
// bit. The read side hands whole packets, one VC at a time, to a local
// consumer and returns one credit per popped flit to the upstream switch.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   data_ready_in  upstream flit valid
//   in             incoming flit (in.vc selects the FIFO, in.payload 32b)
//   credit_granted one-cycle pulse per freed slot, one bit per VC
//   packet_sent    one-cycle pulse after a tail flit is written
//   rvalid         rdata holds a valid flit
//   rdata          head flit of the currently selected VC
//   rlast          rdata is the tail flit of its packet
//   rready         consumer pops rdata when rvalid && rready
//   overflow_err   sticky: a flit was dropped because its FIFO was full
// ---------------------------------------------------------------------------

package switch_link_rx_pkg;
   // The VC field is wide enough for up to 16 VCs; a block built with fewer
   // VCs ignores flits whose vc is out of range.
   localparam int VC_W = 4;

   typedef struct packed {
      logic [VC_W-1:0] vc;
      logic [31:0]     payload;
   } flit_t;
endpackage

module switch_link_rx
   import switch_link_rx_pkg::*;
#(
   parameter int NUM_VCS  = 2,
   parameter int DEPTH    = 8,
   parameter int LEN_BITS = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               data_ready_in,
   input  flit_t              in,
   output logic [NUM_VCS-1:0] credit_granted,
   output logic               packet_sent,
   output logic               rvalid,
   output flit_t              rdata,
   output logic               rlast,
   input  logic               rready,
   output logic               overflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

   typedef enum logic {HDR, BODY} wrState_e;

   typedef struct packed {
      logic  last;
      flit_t flit;
   } entry_t;

   entry_t              mem_q      [NUM_VCS][DEPTH];
   logic [PW-1:0]       wrPtr_q    [NUM_VCS];
   logic [PW-1:0]       rdPtr_q    [NUM_VCS];
   logic [CW-1:0]       count_q    [NUM_VCS];
   wrState_e            state_q    [NUM_VCS];
   logic [LEN_BITS-1:0] remain_q   [NUM_VCS];

   logic [VW-1:0]       sel_q;
   logic [VW-1:0]       lastServed_q;
   logic                locked_q;
   logic [NUM_VCS-1:0]  credit_q;
   logic                packetSent_q;
   logic                overflow_q;

   logic [VW-1:0]       wrVc;
   logic                vcInRange;
   logic                vcFull;
   logic                pushEn;
   logic                pushDrop;
   logic                pushLast;
   logic [LEN_BITS-1:0] hdrLen;
   logic [VW-1:0]       arbVc;
   logic [VW-1:0]       cand;
   logic [VW-1:0]       rdVc;
   entry_t              head;
   logic                pop;
   logic [NUM_VCS-1:0]  pushVec;
   logic [NUM_VCS-1:0]  popVec;

   // Write-side decode. Fullness uses the start-of-cycle count only, so a
   // pop in the same cycle never makes room for the incoming flit.
   assign wrVc      = in.vc[VW-1:0];
   assign vcInRange = 32'(in.vc) < NUM_VCS;
   assign vcFull    = count_q[wrVc] == CW'(DEPTH);
   assign hdrLen    = in.payload[LEN_BITS-1:0];
   assign pushLast  = (state_q[wrVc] == HDR) ? (hdrLen == '0)
                                              : (remain_q[wrVc] == LEN_BITS'(1));
   assign pushEn    = data_ready_in && vcInRange && !vcFull;
   assign pushDrop  = data_ready_in && vcInRange && vcFull;

   // Round-robin pick of the next non-empty VC after the last one served.
   // The loop runs from the farthest candidate to the nearest so the nearest
   // non-empty VC is the one left standing.
   always_comb begin
      cand  = '0;
      arbVc = lastServed_q;
      for (int k = NUM_VCS; k >= 1; k--) begin
         cand = VW'((int'(lastServed_q) + k) % NUM_VCS);
         if (count_q[cand] != '0) begin
            arbVc = cand;
         end
      end
   end

   // Once a packet has started popping, the read side stays on that VC until
   // its tail leaves, even if the FIFO momentarily runs dry.
   assign rdVc   = locked_q ? sel_q : arbVc;
   assign head   = mem_q[rdVc][rdPtr_q[rdVc]];
   assign rvalid = count_q[rdVc] != '0;
   assign rdata  = rvalid ? head.flit : '0;
   assign rlast  = rvalid & head.last;
   assign pop    = rvalid && rready;

   // Per-VC push and pop strobes.
   always_comb begin
      pushVec = '0;
      popVec  = '0;
      for (int v = 0; v < NUM_VCS; v++) begin
         pushVec[v] = pushEn && (wrVc == VW'(v));
         popVec[v]  = pop && (rdVc == VW'(v));
      end
   end

   // FIFO storage, per-VC packet FSMs, read lock and registered pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < NUM_VCS; v++) begin
            wrPtr_q[v]  <= '0;
            rdPtr_q[v]  <= '0;
            count_q[v]  <= '0;
            state_q[v]  <= HDR;
            remain_q[v] <= '0;
         end
         sel_q        <= '0;
         lastServed_q <= VW'(NUM_VCS - 1);
         locked_q     <= 1'b0;
         credit_q     <= '0;
         packetSent_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VCS; v++) begin
            if (pushVec[v]) begin
               mem_q[v][wrPtr_q[v]] <= '{last: pushLast, flit: in};
               wrPtr_q[v]           <= wrPtr_q[v] + 1'b1;
               if (state_q[v] == HDR) begin
                  if (hdrLen != '0) begin
                     state_q[v]  <= BODY;
                     remain_q[v] <= hdrLen;
                  end
               end else begin
                  remain_q[v] <= remain_q[v] - LEN_BITS'(1);
                  if (remain_q[v] == LEN_BITS'(1)) begin
                     state_q[v] <= HDR;
                  end
               end
            end
            if (popVec[v]) begin
               rdPtr_q[v] <= rdPtr_q[v] + 1'b1;
            end
            count_q[v] <= count_q[v] + CW'(pushVec[v]) - CW'(popVec[v]);
         end
         credit_q     <= popVec;
         packetSent_q <= pushEn && pushLast;
         overflow_q   <= overflow_q | pushDrop;
         if (pop) begin
            if (head.last) begin
               locked_q     <= 1'b0;
               lastServed_q <= rdVc;
            end else begin
               locked_q <= 1'b1;
               sel_q    <= rdVc;
            end
         end
      end
   end

   assign credit_granted = credit_q;
   assign packet_sent    = packetSent_q;
   assign overflow_err   = overflow_q;

endmodule

// File: tb/tb_switch_link_rx.sv
// ---------------------------------------------------------------------------
// tb_switch_link_rx
//
// Self-checking bench for switch_link_rx. A queue-based reference model of
// the receive endpoint is stepped alongside the DUT every cycle; on top of
// that, a table of hand-derived vectors and a few directed sequences cover
// the single-flit, multi-flit, interleaved, overflow, wrap-around and
// mid-packet reset cases, followed by a randomized run.
// ---------------------------------------------------------------------------

module tb_switch_link_rx;
   import switch_link_rx_pkg::*;

   localparam int NUM_VCS = 2;
   localparam int DEPTH   = 8;

   logic               clk;
   logic               rst;
   logic               data_ready_in;
   flit_t              inFlit;
   logic [NUM_VCS-1:0] credit_granted;
   logic               packet_sent;
   logic               rvalid;
   flit_t              rdata;
   logic               rlast;
   logic               rready;
   logic               overflow_err;

   switch_link_rx #(
      .NUM_VCS (NUM_VCS),
      .DEPTH   (DEPTH),
      .LEN_BITS(8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .data_ready_in (data_ready_in),
      .in            (inFlit),
      .credit_granted(credit_granted),
      .packet_sent   (packet_sent),
      .rvalid        (rvalid),
      .rdata         (rdata),
      .rlast         (rlast),
      .rready        (rready),
      .overflow_err  (overflow_err)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int testsRun  = 0;
   int failCount = 0;

   // Reference model: one queue per VC holding {payload, last}, plus the
   // number of body flits still owed by the packet in progress on each VC.
   typedef struct {
      logic [31:0] payload;
      logic        last;
   } mEntry_t;

   mEntry_t            mq [NUM_VCS][$];
   int                 mRemain [NUM_VCS];
   bit                 mLocked;
   int                 mSel;
   int                 mLastServed;
   logic [NUM_VCS-1:0] mCredit;
   bit                 mSent;
   bit                 mOverflow;

   // Observations gathered while stepping.
   int          psCount;
   int          crCount [NUM_VCS];
   logic [31:0] popLog[$];
   bit          preValid;
   bit          preLast;
   logic [31:0] preData;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int v = 0; v < NUM_VCS; v++) begin
         mq[v].delete();
         mRemain[v] = 0;
      end
      mLocked     = 0;
      mSel        = 0;
      mLastServed = NUM_VCS - 1;
      mCredit     = '0;
      mSent       = 0;
      mOverflow   = 0;
   endtask

   // VC the consumer should be looking at: the locked one, else the next
   // non-empty VC after the last one served.
   function automatic int modelVc();
      int idx;
      if (mLocked) return mSel;
      for (int k = 1; k <= NUM_VCS; k++) begin
         idx = (mLastServed + k) % NUM_VCS;
         if (mq[idx].size() > 0) return idx;
      end
      return mLastServed;
   endfunction

   function automatic int modelTotal();
      int t = 0;
      for (int v = 0; v < NUM_VCS; v++) t += mq[v].size();
      return t;
   endfunction

   task automatic doReset();
      rst           = 1'b1;
      data_ready_in = 1'b0;
      rready        = 1'b0;
      inFlit        = '0;
      @(posedge clk);
      #1;
      checkOutput("reset credit_granted", credit_granted, 0);
      checkOutput("reset packet_sent", packet_sent, 0);
      checkOutput("reset rvalid", rvalid, 0);
      checkOutput("reset rdata", rdata, 0);
      checkOutput("reset rlast", rlast, 0);
      checkOutput("reset overflow_err", overflow_err, 0);
      rst = 1'b0;
      modelReset();
   endtask

   // One clock cycle: drive inputs, check the read-side view against the
   // model, advance the model, then check the registered pulses.
   task automatic applyStimulus(input bit dv, input int vc, input logic [31:0] payload, input bit rr);
      int      cur;
      bit      expValid;
      bit      full;
      bit      last;
      mEntry_t e;
      data_ready_in  = dv;
      inFlit.vc      = 4'(vc);
      inFlit.payload = payload;
      rready         = rr;
      #1;
      cur      = modelVc();
      expValid = mq[cur].size() > 0;
      preValid = rvalid;
      preLast  = rlast;
      preData  = rdata.payload;
      checkOutput("model rvalid", rvalid, expValid);
      if (expValid) begin
         checkOutput("model rdata", rdata.payload, mq[cur][0].payload);
         checkOutput("model rlast", rlast, mq[cur][0].last);
      end
      if (rvalid && rready) popLog.push_back(rdata.payload);

      full    = mq[vc].size() >= DEPTH;
      mCredit = '0;
      mSent   = 0;
      if (expValid && rr) begin
         e = mq[cur].pop_front();
         mCredit[cur] = 1'b1;
         if (e.last) begin
            mLocked     = 0;
            mLastServed = cur;
         end else begin
            mLocked = 1;
            mSel    = cur;
         end
      end
      if (dv) begin
         if (full) begin
            mOverflow = 1;
         end else begin
            if (mRemain[vc] == 0) begin
               mRemain[vc] = int'(payload[7:0]);
               last        = (payload[7:0] == 8'd0);
            end else begin
               mRemain[vc]--;
               last = (mRemain[vc] == 0);
            end
            mq[vc].push_back('{payload: payload, last: last});
            mSent = last;
         end
      end

      @(posedge clk);
      #1;
      checkOutput("model credit_granted", credit_granted, mCredit);
      checkOutput("model packet_sent", packet_sent, mSent);
      checkOutput("model overflow_err", overflow_err, mOverflow);
      psCount += int'(packet_sent);
      for (int v = 0; v < NUM_VCS; v++) crCount[v] += int'(credit_granted[v]);
   endtask

   typedef struct {
      bit          dv;
      int          vc;
      logic [31:0] payload;
      bit          rr;
      bit          expValid;
      bit          expLast;
      logic [31:0] expData;
      bit          expSent;
      logic [1:0]  expCredit;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          psBase;
      int          crBase;
      int          n;
      logic [31:0] r;
      logic [31:0] p;
      logic [31:0] p9;
      bit          sawDropped;

      psCount = 0;
      for (int v = 0; v < NUM_VCS; v++) crCount[v] = 0;
      rst           = 1'b1;
      data_ready_in = 1'b0;
      rready        = 1'b0;
      inFlit        = '0;
      doReset();

      // Single-flit packet on VC0, then a 3-flit packet on VC1 held and
      // drained.
      vecs[0] = '{1, 0, 32'h0000_0A00, 0, 0, 0, 32'h0,         1, 2'b00};
      vecs[1] = '{0, 0, 32'h0,         1, 1, 1, 32'h0000_0A00, 0, 2'b01};
      vecs[2] = '{0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 2'b00};
      vecs[3] = '{1, 1, 32'h1111_0002, 0, 0, 0, 32'h0,         0, 2'b00};
      vecs[4] = '{1, 1, 32'h0000_B0D1, 0, 1, 0, 32'h1111_0002, 0, 2'b00};
      vecs[5] = '{1, 1, 32'h0000_B0D2, 0, 1, 0, 32'h1111_0002, 1, 2'b00};
      vecs[6] = '{0, 0, 32'h0,         1, 1, 0, 32'h1111_0002, 0, 2'b10};
      vecs[7] = '{0, 0, 32'h0,         1, 1, 0, 32'h0000_B0D1, 0, 2'b10};
      vecs[8] = '{0, 0, 32'h0,         1, 1, 1, 32'h0000_B0D2, 0, 2'b10};
      vecs[9] = '{0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 2'b00};
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].dv, vecs[i].vc, vecs[i].payload, vecs[i].rr);
         checkOutput($sformatf("vec%0d rvalid", i), preValid, vecs[i].expValid);
         if (vecs[i].expValid) begin
            checkOutput($sformatf("vec%0d rlast", i), preLast, vecs[i].expLast);
            checkOutput($sformatf("vec%0d rdata", i), preData, vecs[i].expData);
         end
         checkOutput($sformatf("vec%0d packet_sent", i), packet_sent, vecs[i].expSent);
         checkOutput($sformatf("vec%0d credit_granted", i), credit_granted, vecs[i].expCredit);
      end

      // Interleaved VCs: the lock keeps VC0 selected until its tail leaves.
      popLog.delete();
      psBase = psCount;
      applyStimulus(1, 0, 32'h0A0A_0001, 1);
      applyStimulus(1, 1, 32'h0B0B_0000, 1);
      applyStimulus(1, 0, 32'h0C0C_0055, 1);
      checkOutput("interleave locked idle", preValid, 0);
      applyStimulus(0, 0, 32'h0, 1);
      applyStimulus(0, 0, 32'h0, 1);
      applyStimulus(0, 0, 32'h0, 0);
      checkOutput("interleave pop count", popLog.size(), 3);
      if (popLog.size() == 3) begin
         checkOutput("interleave pop0", popLog[0], 32'h0A0A_0001);
         checkOutput("interleave pop1", popLog[1], 32'h0C0C_0055);
         checkOutput("interleave pop2", popLog[2], 32'h0B0B_0000);
      end
      checkOutput("interleave packet_sent pulses", psCount - psBase, 2);

      // Overflow: fill VC0, then a ninth flit together with a pop.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1, 0, {16'hF0F0, 8'(i), 8'h00}, 0);
      end
      checkOutput("fill no overflow", overflow_err, 0);
      crBase = crCount[0];
      p9     = 32'hF0F0_0900;
      applyStimulus(1, 0, p9, 1);
      checkOutput("overflow set", overflow_err, 1);
      checkOutput("overflow credit", credit_granted, 2'b01);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 32'h0, 0);
         checkOutput("overflow sticky", overflow_err, 1);
      end
      checkOutput("overflow single credit", crCount[0] - crBase, 1);
      popLog.delete();
      n = 0;
      do begin
         applyStimulus(0, 0, 32'h0, 1);
         n++;
      end while (preValid && n < 20);
      checkOutput("overflow remaining entries", popLog.size(), DEPTH - 1);
      sawDropped = 0;
      foreach (popLog[i]) if (popLog[i] == p9) sawDropped = 1;
      checkOutput("overflow dropped flit absent", sawDropped, 0);
      doReset();

      // Wrap-around: 20 back-to-back single-flit packets with rready high.
      popLog.delete();
      psBase = psCount;
      crBase = crCount[0];
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 0, {16'hABCD, 8'(i), 8'h00}, 1);
      end
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h0, 1);
      checkOutput("wrap pop count", popLog.size(), 20);
      if (popLog.size() == 20) begin
         for (int i = 0; i < 20; i++) begin
            p = {16'hABCD, 8'(i), 8'h00};
            checkOutput($sformatf("wrap order %0d", i), popLog[i], p);
         end
      end
      checkOutput("wrap packet_sent pulses", psCount - psBase, 20);
      checkOutput("wrap credits", crCount[0] - crBase, 20);
      checkOutput("wrap no overflow", overflow_err, 0);

      // Reset in the middle of a 4-flit packet on VC1.
      applyStimulus(1, 1, 32'h2222_0003, 0);
      doReset();
      applyStimulus(1, 1, 32'h3333_0000, 0);
      checkOutput("post-reset header is tail", packet_sent, 1);
      applyStimulus(0, 0, 32'h0, 1);
      checkOutput("post-reset rvalid", preValid, 1);
      checkOutput("post-reset rlast", preLast, 1);
      checkOutput("post-reset rdata", preData, 32'h3333_0000);
      applyStimulus(0, 0, 32'h0, 0);

      // Randomized traffic against the model, then drain.
      doReset();
      for (int i = 0; i < 600; i++) begin
         r = $urandom();
         applyStimulus($urandom_range(0, 99) < 70, int'($urandom_range(0, 1)),
                       {r[31:8], 8'($urandom_range(0, 3))}, $urandom_range(0, 99) < 55);
      end
      n = 0;
      while (modelTotal() > 0 && n < 200) begin
         applyStimulus(0, 0, 32'h0, 1);
         n++;
      end
      checkOutput("random drain complete", modelTotal(), 0);
      applyStimulus(0, 0, 32'h0, 1);
      checkOutput("random drained rvalid", preValid, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
